nmea_coord_decoder: RTL and testbench
=====================================

// Module: nmea_coord_decoder
// PURPOSE
//   Converts the ASCII latitude/longitude fields from the NMEA RMC parser into
//   signed fixed-point binary coordinates, in units of 10^-FRAC_DIGITS arc-minutes.
//   Sits directly downstream of the parser and feeds the display/arithmetic stages.
//   One serial digit engine, one character per clock; fixed latency.
// PARAMETERS
//   FRAC_DIGITS  4   minute-fraction digits kept; range 0..5; extra digits truncated, missing digits zero-padded
//   OUT_W        32  width of the signed results; must hold +/-180*60*10^FRAC_DIGITS
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       reset: asynchronous, active-high
//   lat_ready  in   1       parser pulse; starts a decode
//   lon_ready  in   1       parser pulse, asserted together with lat_ready; not used to start
//   sign_lat   in   1       1 = S (negative)
//   sign_lon   in   1       1 = W (negative)
//   lat_len    in   8       number of valid chars in lat_vec
//   lon_len    in   8       number of valid chars in lon_vec
//   lat_vec    in   128     ASCII latitude, char k at bits [8k+7:8k]
//   lon_vec    in   128     ASCII longitude, same packing
//   lat_val    out  OUT_W   signed latitude, minutes*10^FRAC_DIGITS
//   lon_val    out  OUT_W   signed longitude, same scaling
//   coord_valid out 1       1-cycle pulse; new lat_val/lon_val/err_* are presented
//   err_lat    out  1       latitude field malformed or out of range; held until next coord_valid
//   err_lon    out  1       longitude field malformed or out of range; held until next coord_valid
//   busy       out  1       decode in progress
// BEHAVIOUR
//   Reset: all outputs 0, FSM = IDLE. Reset mid-decode aborts; no coord_valid is issued.
//   FSM: IDLE -> LAT_SCAN (16 cyc) -> LAT_FIN (1) -> LON_SCAN (16) -> LON_FIN (1) -> PUBLISH (1) -> IDLE.
//   Start:
//     - lat_ready=1 in IDLE at edge E0: snapshot all inputs; busy=1 from E0.
//     - lat_ready while busy is dropped; there is no queue.
//     - lon_ready alone is ignored.
//   Scan:
//     - Index k=0..15, one per edge; positions k>=len are skipped (no effect).
//     - Pre-dot digit d: deg = deg*10 + mh; mh = ml; ml = d; predot_cnt++.
//       This yields deg, mm = mh*10+ml with no divider.
//     - '.' (first only): switch to fraction mode.
//     - Fraction digits: only the first FRAC_DIGITS are accumulated (frac = frac*10 + d); later ones are ignored.
//   FIN:
//     - val = deg*60*10^F + mm*10^F + frac*10^(F - frac_cnt).
//     - Negate (two's complement) if the sign bit is set; store internally.
//   Error (value forced to 0, err bit set):
//     - len == 0 or len > 16
//     - any char not a digit and not '.'
//     - a second '.'
//     - predot_cnt != 4 (lat) or != 5 (lon)
//     - mm >= 60
//     - |val| > 90*60*10^F (lat) or > 180*60*10^F (lon)
//   A missing '.' is legal: fraction = 0.
//   PUBLISH (edge E35):
//     - lat_val, lon_val, err_lat, err_lon update together; coord_valid=1 for exactly one cycle.
//     - busy=0 after E35; a new start is accepted at E36 at the earliest.
//   Outputs never change except at PUBLISH or reset.
//   Latency: coord_valid is high in the cycle following the 35th rising edge after E0.
// TESTING
//   1. lat "4916.45" N, lon "12311.12" W -> lat_val=29564500, lon_val=-73911200, errs 0, pulse at E35.
//   2. lat "0000.123456" S -> lat_val=-1234 (truncated); lat "0000.1" -> 1000 (padded).
//   3. lat "49A6.45" -> lat_val=0, err_lat=1, lon decoded normally; lat "4961.00" -> err_lat=1; lat "9100.00" -> err_lat=1.
//   4. lat_len=0 and lon_len=0 (no fix) -> both vals 0, err_lat=err_lon=1, coord_valid still pulses.
//   5. Second lat_ready at E10 with different data -> ignored; only the first result is published, exactly one pulse.
//   6. rst at E12 during LAT_SCAN -> outputs 0, busy 0, no pulse; a fresh start then decodes correctly at +35.

Source files
------------

// File: rtl/nmea_coord_decoder.sv
// nmea_coord_decoder: serial ASCII-to-fixed-point decoder for NMEA lat/lon
// fields. One character is consumed per clock from a snapshot of the parser
// outputs; the results come out in units of 10^-FRAC_DIGITS arc-minutes.
module nmea_coord_decoder #(
    parameter int unsigned FRAC_DIGITS = 4,
    parameter int unsigned OUT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lat_ready,
    input  logic                    lon_ready,
    input  logic                    sign_lat,
    input  logic                    sign_lon,
    input  logic [7:0]              lat_len,
    input  logic [7:0]              lon_len,
    input  logic [127:0]            lat_vec,
    input  logic [127:0]            lon_vec,
    output logic signed [OUT_W-1:0] lat_val,
    output logic signed [OUT_W-1:0] lon_val,
    output logic                    coord_valid,
    output logic                    err_lat,
    output logic                    err_lon,
    output logic                    busy
);

    localparam int unsigned MAG_W = 40;

    // 10^e for e in 0..5
    function automatic logic [MAG_W-1:0] pow10(input int unsigned e);
        logic [MAG_W-1:0] p;
        p = MAG_W'(1);
        for (int unsigned i = 0; i < 5; i++) begin
            if (i < e) p = p * MAG_W'(10);
        end
        return p;
    endfunction

    localparam logic [MAG_W-1:0] SCALE   = pow10(FRAC_DIGITS);
    localparam logic [MAG_W-1:0] LAT_LIM = MAG_W'(90 * 60) * SCALE;
    localparam logic [MAG_W-1:0] LON_LIM = MAG_W'(180 * 60) * SCALE;

    typedef enum logic [2:0] {
        IDLE,
        LAT_SCAN,
        LAT_FIN,
        LON_SCAN,
        LON_FIN,
        PUBLISH
    } state_t;

    state_t state, next_state;

    // lon_ready carries no information beyond lat_ready
    logic unused_ok;
    assign unused_ok = lon_ready;

    logic [3:0]       cnt;
    logic [127:0]     lat_vec_r, lon_vec_r;
    logic [7:0]       lat_len_r, lon_len_r;
    logic             sign_lat_r, sign_lon_r;
    logic [15:0]      deg;
    logic [3:0]       mh, ml;
    logic [4:0]       predot_cnt;
    logic [16:0]      frac;
    logic [2:0]       frac_cnt;
    logic             dot_seen;
    logic             bad;
    logic [OUT_W-1:0] lat_res, lon_res;
    logic             lat_bad, lon_bad;

    logic             is_lat_side;
    logic [127:0]     cur_vec;
    logic [7:0]       cur_len;
    logic             cur_sign;
    logic [7:0]       ch;
    logic             in_range;
    logic             is_digit;
    logic [6:0]       mm;
    logic [MAG_W-1:0] mag;
    logic [OUT_W-1:0] mag_o;
    logic             fin_bad;
    logic [OUT_W-1:0] fin_val;

    assign busy = (state != IDLE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // next-state sequencing: fixed 16-char scans with one finish cycle each
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (lat_ready) next_state = LAT_SCAN;
            LAT_SCAN: if (cnt == 4'd15) next_state = LAT_FIN;
            LAT_FIN:  next_state = LON_SCAN;
            LON_SCAN: if (cnt == 4'd15) next_state = LON_FIN;
            LON_FIN:  next_state = PUBLISH;
            PUBLISH:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // current character decode and field finish arithmetic
    always_comb begin
        is_lat_side = (state == LAT_SCAN) || (state == LAT_FIN);
        cur_vec     = is_lat_side ? lat_vec_r : lon_vec_r;
        cur_len     = is_lat_side ? lat_len_r : lon_len_r;
        cur_sign    = is_lat_side ? sign_lat_r : sign_lon_r;
        ch          = cur_vec[{cnt, 3'b000} +: 8];
        in_range    = {4'b0000, cnt} < cur_len;
        is_digit    = (ch >= 8'h30) && (ch <= 8'h39);
        mm          = 7'(mh) * 7'd10 + 7'(ml);
        mag         = MAG_W'(deg) * MAG_W'(60) * SCALE
                    + MAG_W'(mm) * SCALE
                    + MAG_W'(frac) * pow10(FRAC_DIGITS - 32'(frac_cnt));
        mag_o       = OUT_W'(mag);
        fin_bad     = bad
                    || (cur_len == 8'd0) || (cur_len > 8'd16)
                    || (predot_cnt != (is_lat_side ? 5'd4 : 5'd5))
                    || (mm >= 7'd60)
                    || (mag > (is_lat_side ? LAT_LIM : LON_LIM));
        fin_val     = '0;
        if (!fin_bad) fin_val = cur_sign ? -mag_o : mag_o;
    end

    // snapshot, digit accumulation, per-field results and publish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            lat_vec_r   <= '0;
            lon_vec_r   <= '0;
            lat_len_r   <= '0;
            lon_len_r   <= '0;
            sign_lat_r  <= 1'b0;
            sign_lon_r  <= 1'b0;
            deg         <= '0;
            mh          <= '0;
            ml          <= '0;
            predot_cnt  <= '0;
            frac        <= '0;
            frac_cnt    <= '0;
            dot_seen    <= 1'b0;
            bad         <= 1'b0;
            lat_res     <= '0;
            lon_res     <= '0;
            lat_bad     <= 1'b0;
            lon_bad     <= 1'b0;
            lat_val     <= '0;
            lon_val     <= '0;
            err_lat     <= 1'b0;
            err_lon     <= 1'b0;
            coord_valid <= 1'b0;
        end else begin
            coord_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lat_ready) begin
                        lat_vec_r  <= lat_vec;
                        lon_vec_r  <= lon_vec;
                        lat_len_r  <= lat_len;
                        lon_len_r  <= lon_len;
                        sign_lat_r <= sign_lat;
                        sign_lon_r <= sign_lon;
                        cnt        <= '0;
                        deg        <= '0;
                        mh         <= '0;
                        ml         <= '0;
                        predot_cnt <= '0;
                        frac       <= '0;
                        frac_cnt   <= '0;
                        dot_seen   <= 1'b0;
                        bad        <= 1'b0;
                    end
                end
                LAT_SCAN, LON_SCAN: begin
                    // deg/mh/ml form a shift pipeline so the last two pre-dot
                    // digits land in mh:ml without a divide by 100
                    if (in_range) begin
                        if (is_digit) begin
                            if (!dot_seen) begin
                                deg        <= deg * 16'd10 + {12'b0, mh};
                                mh         <= ml;
                                ml         <= ch[3:0];
                                predot_cnt <= predot_cnt + 5'd1;
                            end else if (frac_cnt < 3'(FRAC_DIGITS)) begin
                                frac     <= frac * 17'd10 + {13'b0, ch[3:0]};
                                frac_cnt <= frac_cnt + 3'd1;
                            end
                        end else if (ch == 8'h2E) begin
                            if (dot_seen) bad <= 1'b1;
                            else          dot_seen <= 1'b1;
                        end else begin
                            bad <= 1'b1;
                        end
                    end
                    cnt <= cnt + 4'd1;
                end
                LAT_FIN, LON_FIN: begin
                    if (state == LAT_FIN) begin
                        lat_res <= fin_val;
                        lat_bad <= fin_bad;
                    end else begin
                        lon_res <= fin_val;
                        lon_bad <= fin_bad;
                    end
                    cnt        <= '0;
                    deg        <= '0;
                    mh         <= '0;
                    ml         <= '0;
                    predot_cnt <= '0;
                    frac       <= '0;
                    frac_cnt   <= '0;
                    dot_seen   <= 1'b0;
                    bad        <= 1'b0;
                end
                PUBLISH: begin
                    lat_val     <= lat_res;
                    lon_val     <= lon_res;
                    err_lat     <= lat_bad;
                    err_lon     <= lon_bad;
                    coord_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nmea_coord_decoder.sv
// Self-checking bench for nmea_coord_decoder: a string-level reference model
// predicts every output each cycle; directed cases pin the model with literals.
module tb_nmea_coord_decoder;

    localparam int unsigned F = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               lat_ready = 1'b0;
    logic               lon_ready = 1'b0;
    logic               sign_lat = 1'b0;
    logic               sign_lon = 1'b0;
    logic [7:0]         lat_len = '0;
    logic [7:0]         lon_len = '0;
    logic [127:0]       lat_vec = '0;
    logic [127:0]       lon_vec = '0;
    logic signed [31:0] lat_val;
    logic signed [31:0] lon_val;
    logic               coord_valid;
    logic               err_lat;
    logic               err_lon;
    logic               busy;

    nmea_coord_decoder #(.FRAC_DIGITS(F), .OUT_W(32)) dut (
        .clk(clk), .rst(rst),
        .lat_ready(lat_ready), .lon_ready(lon_ready),
        .sign_lat(sign_lat), .sign_lon(sign_lon),
        .lat_len(lat_len), .lon_len(lon_len),
        .lat_vec(lat_vec), .lon_vec(lon_vec),
        .lat_val(lat_val), .lon_val(lon_val),
        .coord_valid(coord_valid),
        .err_lat(err_lat), .err_lon(err_lon),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint p10(input int e);
        longint p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [127:0] pk(input string s);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < 16; i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    // string-level reference: integer part split with / and %
    function automatic void model_decode(input logic [127:0] v, input int len,
                                         input bit sgn, input bit is_lat,
                                         output longint val, output bit err);
        int dots, pre, fd;
        longint ip, fr, deg, mm, mag, lim;
        logic [7:0] c;
        bit b;
        dots = 0; pre = 0; fd = 0; ip = 0; fr = 0;
        b = (len == 0) || (len > 16);
        if (!b) begin
            for (int i = 0; i < len; i++) begin
                c = v[8*i +: 8];
                if (c == 8'h2E) dots++;
                else if (c >= 8'h30 && c <= 8'h39) begin
                    if (dots == 0) begin
                        ip = ip * 10 + (longint'(c) - 48);
                        pre++;
                    end else if (fd < int'(F)) begin
                        fr = fr * 10 + (longint'(c) - 48);
                        fd++;
                    end
                end else b = 1;
            end
        end
        if (dots > 1) b = 1;
        if (pre != (is_lat ? 4 : 5)) b = 1;
        deg = ip / 100;
        mm  = ip % 100;
        if (mm >= 60) b = 1;
        mag = (deg * 60 + mm) * p10(F) + fr * p10(int'(F) - fd);
        lim = (is_lat ? 90 : 180) * 60 * p10(F);
        if (mag > lim) b = 1;
        err = b;
        val = b ? 0 : (sgn ? -mag : mag);
    endfunction

    // cycle model: accept when idle, publish 35 edges later
    bit     m_active = 0, m_valid = 0, m_elat = 0, m_elon = 0, p_elat, p_elon;
    int     m_age = 0;
    longint m_lat = 0, m_lon = 0, p_lat, p_lon;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_valid = 0; m_age = 0;
            m_lat = 0; m_lon = 0; m_elat = 0; m_elon = 0;
        end else begin
            m_valid = 0;
            if (m_active) begin
                m_age++;
                if (m_age == 35) begin
                    m_lat = p_lat; m_lon = p_lon;
                    m_elat = p_elat; m_elon = p_elon;
                    m_valid = 1; m_active = 0;
                end
            end else if (lat_ready) begin
                m_active = 1; m_age = 0;
                model_decode(lat_vec, int'(lat_len), sign_lat, 1'b1, p_lat, p_elat);
                model_decode(lon_vec, int'(lon_len), sign_lon, 1'b0, p_lon, p_elon);
            end
        end
    end

    // compare every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            check("coord_valid", longint'(coord_valid), longint'(m_valid));
            check("busy", longint'(busy), longint'(m_active));
            check("lat_val", longint'(lat_val), m_lat);
            check("lon_val", longint'(lon_val), m_lon);
            check("err_lat", longint'(err_lat), longint'(m_elat));
            check("err_lon", longint'(err_lon), longint'(m_elon));
        end
        if (coord_valid) pulses++;
    end

    task automatic start_raw(input logic [127:0] lv, input logic [7:0] ll, input bit ls,
                             input logic [127:0] ov, input logic [7:0] ol, input bit os);
        lat_vec = lv; lat_len = ll; sign_lat = ls;
        lon_vec = ov; lon_len = ol; sign_lon = os;
        lat_ready = 1'b1; lon_ready = 1'b1;
        @(posedge clk); #1;
        lat_ready = 1'b0; lon_ready = 1'b0;
        // scramble inputs: the decode must work from its snapshot
        lat_vec = '1; lon_vec = '1; lat_len = 8'd3; lon_len = 8'd3;
        sign_lat = ~ls; sign_lon = ~os;
    endtask

    task automatic start(input string ls, input bit lsg, input string os, input bit osg);
        start_raw(pk(ls), 8'(ls.len()), lsg, pk(os), 8'(os.len()), osg);
    endtask

    // called at E0+1; checks the publish at E35 and the pulse end at E36
    task automatic expect_pub(input string tag, input longint el, input bit eel,
                              input longint eo, input bit eeo);
        repeat (35) @(posedge clk);
        #1;
        check({tag, ".valid"}, longint'(coord_valid), 1);
        check({tag, ".lat"}, longint'(lat_val), el);
        check({tag, ".err_lat"}, longint'(err_lat), longint'(eel));
        check({tag, ".lon"}, longint'(lon_val), eo);
        check({tag, ".err_lon"}, longint'(err_lon), longint'(eeo));
        check({tag, ".busy"}, longint'(busy), 0);
        @(posedge clk); #1;
        check({tag, ".valid_end"}, longint'(coord_valid), 0);
    endtask

    longint mv;
    bit     me;

    initial begin
        // pin the reference model itself
        model_decode(pk("4916.45"), 7, 1'b0, 1'b1, mv, me);
        check("model.lat1", mv, 29564500);
        model_decode(pk("12311.12"), 8, 1'b1, 1'b0, mv, me);
        check("model.lon1", mv, -73911200);
        model_decode(pk("0000.123456"), 11, 1'b1, 1'b1, mv, me);
        check("model.trunc", mv, -1234);

        repeat (3) @(posedge clk);
        #1;
        check("reset.lat", longint'(lat_val), 0);
        check("reset.valid", longint'(coord_valid), 0);
        check("reset.busy", longint'(busy), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        start("4916.45", 0, "12311.12", 1);
        expect_pub("t1", 29564500, 0, -73911200, 0);
        start("0000.123456", 1, "00000.0", 0);
        expect_pub("t2a", -1234, 0, 0, 0);
        start("0000.1", 0, "18000", 0);
        expect_pub("t2b", 1000, 0, 108000000, 0);
        start("49A6.45", 0, "12311.12", 0);
        expect_pub("t3a", 0, 1, 73911200, 0);
        start("4961.00", 0, "18000.0001", 1);
        expect_pub("t3b", 0, 1, 0, 1);
        start("9100.00", 0, "00959.99", 0);
        expect_pub("t3c", 0, 1, 5999900, 0);
        start("9000.00", 1, "1231.12", 0);
        expect_pub("t3d", -54000000, 0, 0, 1);
        start("4916.4.5", 0, "17959.9999", 1);
        expect_pub("t3e", 0, 1, -107999999, 0);
        start("", 0, "", 0);
        expect_pub("t4", 0, 1, 0, 1);
        // length 17 is rejected; chars beyond a valid length are ignored
        start_raw(pk("4916.45"), 8'd17, 1'b0, pk("12311.12ZZ"), 8'd8, 1'b0);
        expect_pub("tlen", 0, 1, 73911200, 0);

        // second lat_ready at E10 must be dropped
        pulses = 0;
        start("4916.45", 0, "12311.12", 1);
        repeat (9) @(posedge clk);
        #1;
        lat_vec = pk("0000.1"); lat_len = 8'd6; lat_ready = 1'b1;
        @(posedge clk); #1;
        lat_ready = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("t5.valid", longint'(coord_valid), 1);
        check("t5.lat", longint'(lat_val), 29564500);
        repeat (8) @(posedge clk);
        #1;
        check("t5.pulses", longint'(pulses), 1);

        // reset during LAT_SCAN aborts the decode
        start("0000.1", 0, "00000.5", 0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        check("t6.busy", longint'(busy), 0);
        check("t6.lat", longint'(lat_val), 0);
        check("t6.lon", longint'(lon_val), 0);
        repeat (40) @(posedge clk);
        #1;
        check("t6.pulses", longint'(pulses), 0);
        start("4916.45", 0, "12311.12", 1);
        expect_pub("t6b", 29564500, 0, -73911200, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
